// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: iterative multiply/divide sequencer that owns HI/LO and stalls the pipeline while busy
module ex_muldiv_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] src_a_i,
    input  logic [DATA_W-1:0] src_b_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [DATA_W-1:0] mf_data_o
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt;
    logic [2*DATA_W-1:0] wk, wk_n, prod;
    logic [DATA_W-1:0]   b_q, hi, lo, abs_a, abs_b;
    logic [DATA_W:0]     sum, shifted, diff;
    logic                neg_q, neg_r, accept, busy, last, sgn, sa, sb;

    // wk holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        busy    = state != IDLE;
        last    = busy && cnt == CW'(DATA_W-1);
        accept  = state == IDLE && valid_i && !flush_i && op_i >= 4'd1 && op_i <= 4'd4;
        sgn     = op_i == 4'd1 || op_i == 4'd3;
        sa      = sgn & src_a_i[DATA_W-1];
        sb      = sgn & src_b_i[DATA_W-1];
        abs_a   = sa ? -src_a_i : src_a_i;
        abs_b   = sb ? -src_b_i : src_b_i;
        sum     = {1'b0, wk[2*DATA_W-1:DATA_W]} + (wk[0] ? {1'b0, b_q} : '0);
        shifted = {wk[2*DATA_W-1:DATA_W], wk[DATA_W-1]};
        diff    = shifted - {1'b0, b_q};
        wk_n    = state == MUL ? {sum, wk[DATA_W-1:1]}
                               : {diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0], wk[DATA_W-2:0], ~diff[DATA_W]};
        prod    = neg_q ? -wk_n : wk_n;
        state_n = flush_i ? IDLE : accept ? (op_i <= 4'd2 ? MUL : DIV) : last ? IDLE : state;
        stall_o = !flush_i && (accept || (busy && !last));
        busy_o  = busy;
        hi_o    = hi;
        lo_o    = lo;
        mf_data_o = op_i == 4'd5 ? hi : op_i == 4'd6 ? lo : '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            cnt   <= '0;
            wk    <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            state <= state_n;
            if (flush_i) begin
                cnt <= '0;
            end else if (accept) begin
                cnt   <= '0;
                wk    <= {{DATA_W{1'b0}}, abs_a};
                b_q   <= abs_b;
                neg_q <= sa ^ sb;
                neg_r <= sa;
            end else if (busy) begin
                cnt <= cnt + CW'(1);
                wk  <= wk_n;
                if (last) begin
                    hi <= state == MUL ? prod[2*DATA_W-1:DATA_W]
                                       : (neg_r ? -wk_n[2*DATA_W-1:DATA_W] : wk_n[2*DATA_W-1:DATA_W]);
                    lo <= state == MUL ? prod[DATA_W-1:0]
                                       : (neg_q ? -wk_n[DATA_W-1:0] : wk_n[DATA_W-1:0]);
                end
            end else if (valid_i && op_i == 4'd7) begin
                hi <= src_a_i;
            end else if (valid_i && op_i == 4'd8) begin
                lo <= src_a_i;
            end
        end
    end
endmodule

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer attached beside the EX stage ALU. It accepts MULT/MULTU/DIV/DIVU from the instruction in EX and runs an iterative shift-add multiply or restoring divide over DATA_W cycles. While the operation runs it stalls the pipeline, and it owns the HI/LO architectural registers. It also serves MFHI/MFLO/MTHI/MTLO. Operands arrive already forwarded (same rs/rt values the ALU sees).

Parameters:
DATA_W, 32, operand/HI/LO width; the iteration count equals DATA_W.

Ports:
clk_i  input  1  clock, all state updates on the rising edge
rst_n_i  input  1  reset; asynchronous, active-low
valid_i  input  1  EX holds a real instruction (not a bubble)
op_i  input  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-15 none
src_a_i  input  DATA_W  forwarded rs (multiplicand / dividend / MTxx source)
src_b_i  input  DATA_W  forwarded rt (multiplier / divisor)
flush_i  input  1  abort in-flight operation, discard result
stall_o  output  1  hold PC, IF/ID, ID/EX; EX/MEM receives a bubble
busy_o  output  1  iteration in progress (state MUL or DIV)
hi_o  output  DATA_W  HI register
lo_o  output  DATA_W  LO register
mf_data_o  output  DATA_W  HI for MFHI, LO for MFLO, else 0; combinational

Behaviour:
- Reset (rst_n_i low, any time incl. mid-operation): state IDLE, counter 0, HI=LO=0, all working registers 0. stall_o=0, busy_o=0, mf_data_o=0 while op_i is not 5/6.
- States: IDLE, MUL, DIV.
- Accept: in IDLE with valid_i=1, op_i in 1..4, flush_i=0. stall_o=1 combinationally in that cycle (T0).
  - At the T0 edge, latch |a| and |b|: absolute value for signed ops, raw for unsigned.
  - Latch neg_q = sign(a)^sign(b) and neg_r = sign(a); both are 0 for unsigned ops.
  - counter=0; next state MUL (ops 1,2) or DIV (ops 3,4).
- MUL: one shift-add step per cycle on a 2*DATA_W accumulator, no early termination.
- DIV: one restoring step per cycle. Remainder is DATA_W+1 bits; quotient shifts in 1 when the trial subtract is non-negative.
- counter increments each busy cycle, running 0..DATA_W-1.
- stall_o = accept_cycle | (busy & counter != DATA_W-1). It is low in the final iteration cycle, so the pipeline advances on the same edge that commits the result. The instruction is never re-accepted.
- Commit at the edge ending counter==DATA_W-1: state IDLE and HI/LO written.
  - MUL: {HI,LO} = product, two's-complement negated if neg_q.
  - DIV: LO = quotient (negated if neg_q), HI = remainder (negated if neg_r).
- Latency: accept at T0, HI/LO valid from T(DATA_W+1). stall_o is high for exactly DATA_W cycles.
- Divide by zero: no trap. Result falls out of the algorithm: unsigned quotient all-ones and remainder = |dividend|, then sign rules apply.
- DIV 0x80000000 / -1 (DATA_W=32): LO=0x80000000, HI=0.
- MTHI/MTLO (valid_i, IDLE, no flush): HI/LO = src_a_i at the next edge, no stall.
- MFHI/MFLO: mf_data_o reflects the current HI/LO. A following instruction cannot reach EX while busy, because the pipeline is stalled.
- op_i 1..8 arriving while busy is impossible by construction; it is ignored.
- flush_i=1:
  - Forces stall_o=0 combinationally.
  - Next edge: state IDLE, counter 0, HI/LO unchanged, no accept.
  - Flush takes priority over accept and commit.
- valid_i=0 or op_i none: no state change.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> stall_o high exactly 32 cycles; HI=0xFFFFFFFE, LO=0x00000001 at T33; busy_o falls at T32 edge.
- MULT -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> LO=0xFFFFFFFF, HI=7. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- MTHI 0x1234 then MFHI next cycle -> mf_data_o=0x1234, stall_o never asserted. Same check for MTLO/MFLO with 0xABCD.
- Seed HI=5,LO=6; DIVU 100/3, flush_i at iteration 5 -> stall_o drops same cycle, busy_o=0 next edge, HI=5/LO=6 retained. Accept with flush_i=1 -> no operation starts.
- MULTU running, rst_n_i low at iteration 10 (between edges) -> stall_o, busy_o, HI, LO go 0 immediately. After release a new MULTU 2x3 -> LO=6 after 33 cycles.
